// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates fetch and load/store ports onto a byte-serial 8-bit RAM bus.
// Replay cycles re-drive the previous address after a bus pause.
module mem_ctrl #(
    parameter int ADDR_WIDTH      = 32,
    parameter bit LAST_GRANT_INIT = 1'b1
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [31:0]           if_data,
    output logic                  if_done,
    input  logic                  ls_req,
    input  logic                  ls_wr,
    input  logic [1:0]            ls_size,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [31:0]           ls_wdata,
    output logic [31:0]           ls_rdata,
    output logic                  ls_done,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
    state_t                r_state, w_state;
    logic                  r_last, w_last, r_is_if, w_is_if, r_rep, w_rep, r_wr, w_wr;
    logic                  r_if_done, w_if_done, r_ls_done, w_ls_done, w_grant_if;
    logic [2:0]            r_n, w_n, r_k, w_k, w_k1;
    logic [ADDR_WIDTH-1:0] r_a, w_a, r_a_prev, w_a_prev;
    logic [3:0][7:0]       r_wdata, w_wdata, r_buf, w_buf;
    logic [7:0]            r_dout, w_dout;
    logic [31:0]           r_if_data, w_if_data, r_ls_rdata, w_ls_rdata;

    always_comb begin
        w_state    = r_state;
        w_last     = r_last;
        w_is_if    = r_is_if;
        w_rep      = r_rep;
        w_wr       = r_wr;
        w_if_done  = r_if_done;
        w_ls_done  = r_ls_done;
        w_n        = r_n;
        w_k        = r_k;
        w_a        = r_a;
        w_a_prev   = r_a_prev;
        w_wdata    = r_wdata;
        w_buf      = r_buf;
        w_dout     = r_dout;
        w_if_data  = r_if_data;
        w_ls_rdata = r_ls_rdata;
        w_k1       = r_k + 3'd1;
        w_grant_if = if_req && (!ls_req || !r_last);
        if (!rdy_in) begin
            w_rep = r_rep || (r_state == RD);
        end else begin
            case (r_state)
                IDLE: if (if_req || ls_req) begin
                    w_is_if  = w_grant_if;
                    w_last   = w_grant_if;
                    w_a      = w_grant_if ? if_addr : ls_addr;
                    w_a_prev = w_a;
                    w_n      = (w_grant_if || ls_size[1]) ? 3'd4 : (ls_size[0] ? 3'd2 : 3'd1);
                    w_wdata  = ls_wdata;
                    w_k      = '0;
                    w_buf    = '0;
                    w_wr     = !w_grant_if && ls_wr;
                    w_dout   = w_wr ? ls_wdata[7:0] : 8'd0;
                    w_state  = w_wr ? WR : RD;
                end
                RD: if (r_rep) begin
                    w_rep = 1'b0;
                end else begin
                    // mem_din now carries the byte addressed in the previous cycle
                    if (r_k != 3'd0) w_buf[r_k[1:0] - 2'd1] = mem_din;
                    if (r_k == r_n) begin
                        w_state    = DONE;
                        w_a        = '0;
                        w_if_done  = r_is_if;
                        w_ls_done  = !r_is_if;
                        w_if_data  = r_is_if ? w_buf : r_if_data;
                        w_ls_rdata = r_is_if ? r_ls_rdata : w_buf;
                    end else begin
                        w_k      = w_k1;
                        w_a_prev = r_a;
                        w_a      = (w_k1 == r_n) ? r_a : r_a + ADDR_WIDTH'(1);
                    end
                end
                WR: if (w_k1 == r_n) begin
                    w_state   = DONE;
                    w_wr      = 1'b0;
                    w_a       = '0;
                    w_dout    = 8'd0;
                    w_ls_done = 1'b1;
                end else begin
                    w_k    = w_k1;
                    w_a    = r_a + ADDR_WIDTH'(1);
                    w_dout = r_wdata[w_k1[1:0]];
                end
                DONE: begin
                    w_state   = IDLE;
                    w_if_done = 1'b0;
                    w_ls_done = 1'b0;
                end
                default: w_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= IDLE;
            r_last     <= LAST_GRANT_INIT;
            r_is_if    <= 1'b0;
            r_rep      <= 1'b0;
            r_wr       <= 1'b0;
            r_if_done  <= 1'b0;
            r_ls_done  <= 1'b0;
            r_n        <= '0;
            r_k        <= '0;
            r_a        <= '0;
            r_a_prev   <= '0;
            r_wdata    <= '0;
            r_buf      <= '0;
            r_dout     <= '0;
            r_if_data  <= '0;
            r_ls_rdata <= '0;
        end else begin
            r_state    <= w_state;
            r_last     <= w_last;
            r_is_if    <= w_is_if;
            r_rep      <= w_rep;
            r_wr       <= w_wr;
            r_if_done  <= w_if_done;
            r_ls_done  <= w_ls_done;
            r_n        <= w_n;
            r_k        <= w_k;
            r_a        <= w_a;
            r_a_prev   <= w_a_prev;
            r_wdata    <= w_wdata;
            r_buf      <= w_buf;
            r_dout     <= w_dout;
            r_if_data  <= w_if_data;
            r_ls_rdata <= w_ls_rdata;
        end
    end

    assign mem_a    = r_rep ? r_a_prev : r_a;
    assign mem_wr   = r_wr && rdy_in;
    assign mem_dout = r_dout;
    assign if_data  = r_if_data;
    assign if_done  = r_if_done;
    assign ls_rdata = r_ls_rdata;
    assign ls_done  = r_ls_done;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: table-driven and hand-sequenced checks of mem_ctrl against a byte RAM model.
module tb_mem_ctrl;
    logic        clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1;
    logic        if_req = 1'b0, ls_req = 1'b0, ls_wr = 1'b0;
    logic [1:0]  ls_size = '0;
    logic [31:0] if_addr = '0, ls_addr = '0, ls_wdata = '0;
    logic [31:0] if_data, ls_rdata, mem_a;
    logic        if_done, ls_done, mem_wr;
    logic [7:0]  mem_din = '0, mem_dout;
    int          checks = 0, failures = 0;
    logic [7:0]  ram [65536];
    logic [7:0]  shadow [65536];
    bit          ram_init = 1'b1, logging = 1'b0;
    logic [31:0] a_log [$];
    logic [7:0]  d_log [$];
    bit          w_log [$], r_log [$];

    typedef struct {bit is_if; bit chk_data; logic [31:0] data;} exp_t;
    typedef struct {bit is_if; bit wr; logic [1:0] size; logic [31:0] addr; logic [31:0] wdata; int pa; int pl; int lat;} vec_t;
    exp_t sb [$];
    exp_t sb_e;
    vec_t tbl [13];

    always #5 clk_in = ~clk_in;

    mem_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
        .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_done(ls_done),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    function automatic logic [7:0] init_val(input int i);
        case (i)
            'h100: return 8'h13;
            'h101: return 8'h05;
            'h102: return 8'h10;
            'h103: return 8'h00;
            'h40:  return 8'h11;
            'h41:  return 8'h22;
            'h42:  return 8'h33;
            'h43:  return 8'h44;
            default: return 8'(i * 37 + 11);
        endcase
    endfunction

    // RAM with 1-cycle read latency; while paused the host owns the bus at 0x1FFFF
    always @(posedge clk_in) begin
        if (ram_init) begin
            for (int i = 0; i < 65536; i++) ram[i] <= init_val(i);
        end else if (mem_wr) begin
            ram[mem_a[15:0]] <= mem_dout;
        end
        mem_din <= ram[rdy_in ? mem_a[15:0] : 16'hFFFF];
    end

    always @(negedge clk_in) if (logging) begin
        a_log.push_back(mem_a);
        d_log.push_back(mem_dout);
        w_log.push_back(mem_wr);
        r_log.push_back(rdy_in);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    always @(negedge clk_in) if ((if_done || ls_done) && rdy_in) begin
        if (sb.size() == 0) begin
            chk("sb_unexpected_done", {30'd0, if_done, ls_done}, 32'd0);
        end else begin
            sb_e = sb.pop_front();
            chk("sb_port", {30'd0, if_done, ls_done}, sb_e.is_if ? 32'd2 : 32'd1);
            if (sb_e.chk_data) chk("sb_data", sb_e.is_if ? if_data : ls_rdata, sb_e.data);
        end
    end

    function automatic logic [31:0] model_rd(input logic [31:0] addr, input int n);
        logic [31:0] x = '0;
        logic [31:0] ak;
        for (int k = 0; k < n; k++) begin
            ak = addr + k;
            x[8*k +: 8] = shadow[ak[15:0]];
        end
        return x;
    endfunction

    task automatic reset_dut();
        rst_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1 rst_in = 1'b0;
    endtask

    task automatic do_req(input bit is_if, input bit wr, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input int pa, input int pl, input int exp_lat);
        int n, lat, cnt;
        bit done;
        exp_t e;
        logic [31:0] ak;
        n = (is_if || size[1]) ? 4 : (size[0] ? 2 : 1);
        e.is_if = is_if;
        e.chk_data = !wr;
        e.data = model_rd(addr, n);
        if (wr) for (int k = 0; k < n; k++) begin
            ak = addr + k;
            shadow[ak[15:0]] = wdata[8*k +: 8];
        end
        sb.push_back(e);
        a_log.delete(); d_log.delete(); w_log.delete(); r_log.delete();
        logging = 1'b1;
        if_addr = addr; ls_addr = addr; ls_wr = wr; ls_size = size; ls_wdata = wdata;
        if (is_if) if_req = 1'b1; else ls_req = 1'b1;
        if (pl > 0 && pa == 0) rdy_in = 1'b0;
        lat = 0;
        done = 1'b0;
        while (!done && lat < 40) begin
            @(posedge clk_in);
            #1 lat++;
            if (pl > 0 && lat == pa) rdy_in = 1'b0;
            if (pl > 0 && lat == pa + pl) rdy_in = 1'b1;
            done = is_if ? if_done : ls_done;
        end
        chk("latency", lat, exp_lat);
        rdy_in = 1'b1;
        if_req = 1'b0;
        ls_req = 1'b0;
        @(posedge clk_in);
        #1 logging = 1'b0;
        chk("idle_addr", mem_a, 32'd0);
        if (pl == 0 && a_log.size() > n + 1) begin
            for (int k = 0; k < n; k++) begin
                chk("bus_addr", a_log[1+k], addr + k);
                if (wr) begin
                    chk("bus_wr", {31'd0, w_log[1+k]}, 32'd1);
                    chk("bus_dout", {24'd0, d_log[1+k]}, {24'd0, wdata[8*k +: 8]});
                end
            end
            if (!wr) chk("bus_final_hold", a_log[n+1], addr + n - 1);
        end
        cnt = 0;
        foreach (w_log[i]) cnt += int'(w_log[i]);
        chk("wr_count", cnt, wr ? n : 0);
    endtask

    initial begin
        int turn;
        bit seen;
        #20000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit exp_if, seen;
        exp_t e;
        for (int i = 0; i < 65536; i++) shadow[i] = init_val(i);
        tbl[0]  = '{0, 0, 2'd2, 32'h0000_0202, 32'h0, 0, 0, 6};
        tbl[1]  = '{0, 0, 2'd0, 32'hFFFF_FFFF, 32'h0, 0, 0, 3};
        tbl[2]  = '{0, 1, 2'd0, 32'h0000_0300, 32'h1234_5678, 0, 0, 2};
        tbl[3]  = '{0, 0, 2'd1, 32'h0000_0300, 32'h0, 0, 0, 4};
        tbl[4]  = '{0, 1, 2'd2, 32'h0000_0301, 32'hCAFE_F00D, 0, 0, 5};
        tbl[5]  = '{0, 0, 2'd3, 32'h0000_0300, 32'h0, 0, 0, 6};
        tbl[6]  = '{1, 0, 2'd0, 32'h0000_02FF, 32'h0, 0, 0, 6};
        tbl[7]  = '{0, 1, 2'd2, 32'h0000_0500, 32'h0D0C_0B0A, 2, 2, 7};
        tbl[8]  = '{0, 0, 2'd2, 32'h0000_0500, 32'h0, 0, 0, 6};
        tbl[9]  = '{0, 0, 2'd0, 32'h0000_0041, 32'h0, 0, 2, 5};
        tbl[10] = '{0, 0, 2'd1, 32'h0000_0600, 32'h0, 2, 1, 6};
        tbl[11] = '{0, 1, 2'd1, 32'h0000_0700, 32'h0000_BEEF, 0, 0, 3};
        tbl[12] = '{0, 0, 2'd2, 32'h0000_06FF, 32'h0, 0, 0, 6};
        reset_dut();
        ram_init = 1'b0;
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        chk("rst_done", {30'd0, if_done, ls_done}, 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_ls_rdata", ls_rdata, 32'd0);
        // both requesters held in IDLE: ls first after reset, then alternate
        if_addr = 32'h100; ls_addr = 32'h40; ls_wr = 1'b0; ls_size = 2'd2;
        for (int t = 0; t < 5; t++) begin
            exp_if = (t % 2) == 1;
            e.is_if = exp_if;
            e.chk_data = 1'b1;
            e.data = model_rd(exp_if ? 32'h100 : 32'h40, 4);
            sb.push_back(e);
            if_req = 1'b1;
            ls_req = 1'b1;
            seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                @(posedge clk_in);
                #1 seen = if_done || ls_done;
            end
            chk("arb_turn", {30'd0, if_done, ls_done}, exp_if ? 32'd2 : 32'd1);
            if (if_done) if_req = 1'b0;
            if (ls_done) ls_req = 1'b0;
            @(posedge clk_in);
            #1;
        end
        if_req = 1'b0;
        ls_req = 1'b0;
        do_req(1, 0, 2'd0, 32'h100, 32'h0, 0, 0, 6);
        chk("fetch_word", if_data, 32'h0010_0513);
        do_req(0, 1, 2'd1, 32'h203, 32'hAABB_CCDD, 0, 0, 3);
        chk("store_half_b0", {24'd0, ram[16'h203]}, 32'hDD);
        chk("store_half_b1", {24'd0, ram[16'h204]}, 32'hCC);
        chk("store_half_untouched", {24'd0, ram[16'h205]}, {24'd0, init_val('h205)});
        for (int i = 0; i < 13; i++)
            do_req(tbl[i].is_if, tbl[i].wr, tbl[i].size, tbl[i].addr, tbl[i].wdata, tbl[i].pa, tbl[i].pl, tbl[i].lat);
        chk("ram_after_paused_wr", {24'd0, ram[16'h501]}, 32'h0B);
        chk("if_data_held", if_data, model_rd(32'h2FF, 4));
        // pause after the 0x41 address cycle; replay must re-drive 0x41
        do_req(0, 0, 2'd2, 32'h40, 32'h0, 3, 3, 10);
        chk("replay_addr", a_log[6], 32'h41);
        chk("replay_rdy", {31'd0, r_log[6]}, 32'd1);
        chk("replay_next", a_log[7], 32'h42);
        chk("replay_data", ls_rdata, 32'h4433_2211);
        do_req(0, 0, 2'd0, 32'hFFFF_FFFF, 32'h0, 0, 0, 3);
        chk("byte_zero_ext", ls_rdata, 32'h0000_00E6);
        do_req(0, 0, 2'd2, 32'hFFFF_FFFE, 32'h0, 0, 0, 6);
        chk("wrap_a2", a_log[3], 32'h0);
        chk("wrap_a3", a_log[4], 32'h1);
        chk("wrap_data", ls_rdata, 32'h300B_E6C1);
        // reset during the second byte of a word store
        ls_addr = 32'h80; ls_wr = 1'b1; ls_size = 2'd2; ls_wdata = 32'h4433_2211; ls_req = 1'b1;
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b1;
        @(posedge clk_in);
        #1 rst_in = 1'b0;
        ls_req = 1'b0;
        chk("rstwr_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rstwr_mem_a", mem_a, 32'd0);
        chk("rstwr_ls_rdata", ls_rdata, 32'd0);
        chk("rstwr_if_data", if_data, 32'd0);
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk_in);
            #1 seen = seen || ls_done;
        end
        chk("rstwr_no_done", {31'd0, seen}, 32'd0);
        chk("rstwr_b0", {24'd0, ram[16'h80]}, 32'h11);
        chk("rstwr_b1", {24'd0, ram[16'h81]}, 32'h22);
        chk("rstwr_b2", {24'd0, ram[16'h82]}, {24'd0, init_val('h82)});
        chk("rstwr_b3", {24'd0, ram[16'h83]}, {24'd0, init_val('h83)});
        shadow[16'h80] = 8'h11;
        shadow[16'h81] = 8'h22;
        do_req(0, 0, 2'd2, 32'h80, 32'h0, 0, 0, 6);
        repeat (2) @(posedge clk_in);
        chk("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Byte-serial memory controller between the CPU's internal requesters and the 8-bit system memory bus (mem_a/mem_wr/mem_dout/mem_din). It sits inside cpu, clocked by the divided CPU clock.
- Arbitrates between an instruction-fetch port (4-byte reads) and a load/store port (1/2/4-byte reads/writes), round-robin on ties.
- Splits each request into little-endian byte cycles against a RAM with 1-cycle read latency.
- Honours the rdy_in pause, including a replay cycle after the bus is returned.

Parameters:
ADDR_WIDTH, 32, width of request and bus addresses
LAST_GRANT_INIT, 1, value of the last-grant flag after reset (1 = fetch granted last, so load/store wins the first tie)

Ports:
clk_in  input  1  clock
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  0 = bus lent to the host interface; controller frozen
if_req  input  1  fetch request, held until if_done
if_addr  input  ADDR_WIDTH  fetch byte address
if_data  output  32  fetched word, valid from the if_done cycle, held until the next fetch completes
if_done  output  1  one-cycle completion pulse
ls_req  input  1  load/store request, held until ls_done
ls_wr  input  1  1 = store, 0 = load
ls_size  input  2  00 = byte, 01 = half, 10 = word, 11 = treated as word
ls_addr  input  ADDR_WIDTH  byte address
ls_wdata  input  32  store data, low bytes used
ls_rdata  output  32  load data, zero-extended; valid from ls_done, held until the next load completes
ls_done  output  1  one-cycle completion pulse
mem_din  input  8  bus read data (address of previous cycle)
mem_dout  output  8  bus write data
mem_a  output  ADDR_WIDTH  bus address
mem_wr  output  1  bus write strobe

Behaviour:
- Reset (rst_in high at an edge; priority over rdy_in):
  - State goes to IDLE; last-grant flag = LAST_GRANT_INIT.
  - mem_a=0, mem_wr=0, mem_dout=0, if_done=0, ls_done=0, if_data=0, ls_rdata=0.
  - An access interrupted mid-stream is abandoned. Bytes already written stay written.
- States: IDLE, RD, WR, DONE. All outputs are registered.
- IDLE:
  - Drives mem_a=0, mem_wr=0.
  - Samples requests only here. Only one requester pending → grant it. Both pending → grant the one not granted last. Update the flag.
  - Latch addr, n (1/2/4; fetch n=4) and wdata. Go to RD or WR.
- RD (n+1 cycles, k=0..n):
  - Cycle k<n drives mem_a=addr+k, mem_wr=0.
  - Cycle k>=1 captures mem_din into byte k-1.
  - Cycle n holds mem_a and performs the final capture only.
  - Then go to DONE.
- WR (n cycles, k=0..n-1): mem_a=addr+k, mem_dout=wdata[8k+7:8k], mem_wr=1. Then go to DONE.
- DONE (1 cycle):
  - Drives mem_wr=0, mem_a=0.
  - Asserts the granted port's done. Data register already updated; unused upper bytes = 0.
  - Requester must drop req at the edge ending DONE; req is ignored in DONE. Next state IDLE.
- Latency from req high in IDLE at cycle T:
  - Word read: done at T+6; byte read: T+3; half read: T+4.
  - Word write: T+5; byte write: T+2.
- Address arithmetic: addr+k is modulo 2^ADDR_WIDTH. Misaligned accesses are legal and fully byte-serial.
- rdy_in=0:
  - No state, counter, capture or output-register change.
  - mem_wr is forced to 0 combinationally.
  - If paused during RD, set a replay flag. On the first rdy_in=1 cycle, re-drive mem_a=addr+k and suppress capture. Normal RD sequencing resumes the next cycle.
  - A WR byte pending when paused is issued once after resume, never twice.
- rdy_in=0 in IDLE: no grant. In DONE: done stays asserted until the DONE cycle completes with rdy_in=1.
- A read replay can re-issue an I/O address (addr bit 17 set). The host interface must tolerate duplicate I/O reads only under pause.

Test Plan:
- Word fetch if_addr=0x00000100, RAM bytes 0x13,0x05,0x10,0x00 → mem_a 0x100..0x103 on consecutive cycles, if_done at T+6, if_data=0x00100513.
- Store half ls_addr=0x203, ls_wdata=0xAABBCCDD → mem_wr=1 at 0x203 (0xDD) then 0x204 (0xCC), ls_done at T+3, RAM[0x205] untouched.
- Both requesters high in IDLE after reset → ls granted first. With both re-asserted on every turn, grants alternate if, ls, if, ls.
- Word load at 0x40, rdy_in low for 3 cycles after the second address cycle, with the bus driven to 0x1FFFF meanwhile → one replay cycle at 0x41, ls_rdata equals RAM[0x40..0x43] exactly, no mem_wr pulse.
- rst_in asserted during WR byte 2 of a word store to 0x80 → next cycle mem_wr=0, mem_a=0, state IDLE. RAM[0x80..0x81] written, 0x82..0x83 unchanged, no ls_done.
- Load byte at 0xFFFFFFFF, then a word load at 0xFFFFFFFE → second access addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1; ls_rdata upper bytes zero for the byte load.
